// File: rtl/norm_sequencer.sv
// ============================================================================
//  Module   : norm_sequencer
//  Purpose  : Per-core sequencer for the two-core row normalization pass
//             (read psum, accumulate, exchange sums, divide, write back).
//             Optional peer-wait watchdog enabled by macro NORM_SEQ_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module norm_sequencer #(
    parameter int ROW_BW      = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_BW       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROW_BW-1:0] num_rows,
    input  logic              fifo_ext_empty,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ROW_BW-1:0] norm_mem_addr,
    output logic              norm_mem_rd,
    output logic              norm_mem_wr,
    output logic [1:0]        sfp_inst,
    output logic              wr_sum,
    output logic              fifo_ext_rd
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_READ  = 4'd1;
    localparam logic [3:0] ST_ACC   = 4'd2;
    localparam logic [3:0] ST_SEND  = 4'd3;
    localparam logic [3:0] ST_WAIT  = 4'd4;
    localparam logic [3:0] ST_FETCH = 4'd5;
    localparam logic [3:0] ST_DIV   = 4'd6;
    localparam logic [3:0] ST_WRITE = 4'd7;
    localparam logic [3:0] ST_DONE  = 4'd8;

    localparam logic [1:0] SFP_IDLE = 2'b00;
    localparam logic [1:0] SFP_ACC  = 2'b01;
    localparam logic [1:0] SFP_DIV  = 2'b10;

    logic [3:0]        r_state;
    logic [3:0]        w_next_state;
    logic [ROW_BW-1:0] r_row;
    logic [ROW_BW-1:0] r_last;
    logic              r_err;
    logic              w_timeout_hit;
    logic              w_accept;

    assign w_accept = (r_state == ST_IDLE) && start;

    generate
        if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (2**TO_BW) - 1) begin : g_bad_timeout
            $error("norm_sequencer: TIMEOUT_CYC does not fit in TO_BW bits");
        end
    endgenerate

`ifdef NORM_SEQ_TIMEOUT_EN
    logic [TO_BW-1:0] r_wd_cnt;

    // Hit fires on the TIMEOUT_CYC-th consecutive empty WAIT cycle.
    assign w_timeout_hit = (r_state == ST_WAIT) && fifo_ext_empty &&
                           (r_wd_cnt == TO_BW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if ((r_state == ST_WAIT) && fifo_ext_empty && !w_timeout_hit) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end else begin
            r_wd_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_timeout_hit) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign r_err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row  <= '0;
            r_last <= '0;
        end else if (w_accept) begin
            r_row  <= '0;
            r_last <= num_rows;
        end else if ((r_state == ST_WRITE) && (r_row != r_last)) begin
            r_row  <= r_row + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  w_next_state = start ? ST_READ : ST_IDLE;
            ST_READ:  w_next_state = ST_ACC;
            ST_ACC:   w_next_state = ST_SEND;
            ST_SEND:  w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (w_timeout_hit) begin
                    w_next_state = ST_IDLE;
                end else if (!fifo_ext_empty) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: w_next_state = ST_DIV;
            ST_DIV:   w_next_state = ST_WRITE;
            // Compare before increment so an all-ones last row never wraps.
            ST_WRITE: w_next_state = (r_row == r_last) ? ST_DONE : ST_READ;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        norm_mem_rd   = 1'b0;
        norm_mem_wr   = 1'b0;
        wr_sum        = 1'b0;
        fifo_ext_rd   = 1'b0;
        sfp_inst      = SFP_IDLE;
        norm_mem_addr = '0;
        case (r_state)
            ST_READ: begin
                norm_mem_rd   = 1'b1;
                norm_mem_addr = r_row;
            end
            ST_ACC: begin
                sfp_inst      = SFP_ACC;
                norm_mem_addr = r_row;
            end
            ST_SEND: begin
                wr_sum        = 1'b1;
                norm_mem_addr = r_row;
            end
            ST_WAIT: begin
                norm_mem_addr = r_row;
            end
            ST_FETCH: begin
                fifo_ext_rd   = 1'b1;
                norm_mem_addr = r_row;
            end
            ST_DIV: begin
                sfp_inst      = SFP_DIV;
                norm_mem_addr = r_row;
            end
            ST_WRITE: begin
                norm_mem_wr   = 1'b1;
                norm_mem_addr = r_row;
            end
            default: begin
                norm_mem_addr = '0;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_norm_sequencer.sv
// ============================================================================
//  Module   : tb_norm_sequencer
//  Purpose  : Randomized self-checking bench for norm_sequencer against a
//             row-by-row cycle script derived from the pass rules.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_norm_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] num_rows = 4'd0;
    logic       fifo_ext_empty = 1'b0;
    logic       busy, done, err;
    logic [3:0] norm_mem_addr;
    logic       norm_mem_rd, norm_mem_wr;
    logic [1:0] sfp_inst;
    logic       wr_sum, fifo_ext_rd;

    int checks = 0;
    int errors = 0;

    norm_sequencer #(.ROW_BW(4), .TIMEOUT_CYC(20), .TO_BW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .fifo_ext_empty(fifo_ext_empty), .busy(busy), .done(done), .err(err),
        .norm_mem_addr(norm_mem_addr), .norm_mem_rd(norm_mem_rd),
        .norm_mem_wr(norm_mem_wr), .sfp_inst(sfp_inst), .wr_sum(wr_sum),
        .fifo_ext_rd(fifo_ext_rd)
    );

    always #5 clk = ~clk;

    // One entry per expected cycle of a pass, starting with the cycle after start.
    typedef struct {
        logic       rd, wr, ws, fr, dn, in_wait, empty;
        logic [1:0] sfp;
        int         addr;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t mk(input logic rd, wr, ws, fr, dn, input logic [1:0] sfp,
                                input int addr);
        exp_t e;
        e.rd = rd; e.wr = wr; e.ws = ws; e.fr = fr; e.dn = dn; e.sfp = sfp;
        e.addr = addr; e.in_wait = 1'b0; e.empty = 1'b0;
        return e;
    endfunction

    task automatic run_pass(input string name, input int n, input int smin, input int smax,
                            input bit noise, input bit start_in_done, input int abort_row,
                            output int done_cyc);
        int   abort_idx;
        int   ws_cnt;
        int   fr_cnt;
        int   s;
        exp_t e;
        logic [8:0] obs, expv;
        logic [3:0] ea;
        abort_idx = -1;
        ws_cnt = 0;
        fr_cnt = 0;
        done_cyc = -1;
        exp_q.delete();
        for (int r = 0; r <= n; r++) begin
            exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, r));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b01, -1));
            exp_q.push_back(mk(0, 0, 1, 0, 0, 2'b00, -1));
            s = $urandom_range(smax, smin);
            for (int j = 0; j <= s; j++) begin
                e = mk(0, 0, 0, 0, 0, 2'b00, -1);
                e.in_wait = 1'b1;
                e.empty = (j < s);
                exp_q.push_back(e);
            end
            exp_q.push_back(mk(0, 0, 0, 1, 0, 2'b00, -1));
            if (r == abort_row) abort_idx = exp_q.size();
            exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, -1));
            exp_q.push_back(mk(0, 1, 0, 0, 0, 2'b00, r));
        end
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0));

        num_rows = n[3:0];
        start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            e = exp_q[i];
            obs  = {busy, done, err, norm_mem_rd, norm_mem_wr, wr_sum, fifo_ext_rd, sfp_inst};
            expv = {1'b1, e.dn, 1'b0, e.rd, e.wr, e.ws, e.fr, e.sfp};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL %s cycle %0d outputs{busy,done,err,rd,wr,ws,fr,sfp} got %b want %b",
                         name, i + 1, obs, expv);
            end
            if (e.addr >= 0) begin
                ea = e.addr[3:0];
                checks++;
                if (norm_mem_addr !== ea) begin
                    errors++;
                    $display("FAIL %s cycle %0d addr got %0d want %0d", name, i + 1, norm_mem_addr, ea);
                end
            end
            if (wr_sum === 1'b1) ws_cnt++;
            if (fifo_ext_rd === 1'b1) fr_cnt++;
            if (done === 1'b1 && done_cyc < 0) done_cyc = i + 1;
            if (i == abort_idx) begin
                reset = 1'b1;
                start = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    obs = {busy, done, err, norm_mem_rd, norm_mem_wr, wr_sum, fifo_ext_rd, sfp_inst};
                    checks++;
                    if (obs !== 9'd0 || norm_mem_addr !== 4'd0) begin
                        errors++;
                        $display("FAIL %s after_reset+%0d outputs got %b addr %0d want 0", name, k,
                                 obs, norm_mem_addr);
                    end
                    @(negedge clk);
                end
                done_cyc = -1;
                return;
            end
            fifo_ext_empty = e.in_wait ? e.empty : 1'($urandom_range(1, 0));
            start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            if (noise) num_rows = 4'($urandom);
            if (start_in_done && e.dn) start = 1'b1;
        end
        @(negedge clk);
        obs = {busy, done, err, norm_mem_rd, norm_mem_wr, wr_sum, fifo_ext_rd, sfp_inst};
        checks++;
        if (obs !== 9'd0 || norm_mem_addr !== 4'd0) begin
            errors++;
            $display("FAIL %s idle_after_done got %b addr %0d want 0", name, obs, norm_mem_addr);
        end
        checks++;
        if (ws_cnt != n + 1 || fr_cnt != n + 1) begin
            errors++;
            $display("FAIL %s pulse_counts wr_sum %0d fifo_rd %0d want %0d each", name, ws_cnt,
                     fr_cnt, n + 1);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err, norm_mem_rd, norm_mem_wr, wr_sum, fifo_ext_rd, sfp_inst, norm_mem_addr}
            !== 13'd0) begin
            errors++;
            $display("FAIL reset outputs got busy %b done %b addr %0d sfp %b want all 0", busy, done,
                     norm_mem_addr, sfp_inst);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int dc;
        run_pass("basic_n3", 3, 0, 0, 0, 0, -1, dc);
        checks++;
        if (dc != 29) begin
            errors++;
            $display("FAIL basic_done_cycle got %0d want 29", dc);
        end
    endtask

    task automatic test_stall();
        int dc;
        run_pass("stall_n0", 0, 10, 10, 0, 0, -1, dc);
        checks++;
        if (dc != 18) begin
            errors++;
            $display("FAIL stall_done_cycle got %0d want 18", dc);
        end
    endtask

    task automatic test_start_ignored();
        int dc;
        run_pass("start_noise", 3, 0, 3, 1, 0, -1, dc);
    endtask

    task automatic test_reset_mid();
        int dc;
        run_pass("reset_mid", 3, 0, 2, 0, 0, 2, dc);
        run_pass("after_reset", 2, 0, 2, 0, 0, -1, dc);
    endtask

    task automatic test_full();
        int dc;
        run_pass("full_n15", 15, 0, 0, 0, 0, -1, dc);
        checks++;
        if (dc != 113) begin
            errors++;
            $display("FAIL full_done_cycle got %0d want 113", dc);
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        run_pass("b2b_first", 2, 0, 2, 0, 1, -1, dc);
        run_pass("b2b_second", 1, 0, 2, 0, 0, -1, dc);
    endtask

    task automatic test_random();
        int dc;
        for (int p = 0; p < 6; p++) begin
            run_pass("random", $urandom_range(15, 0), 0, 5, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), -1, dc);
        end
    endtask

`ifdef NORM_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int dc;
        num_rows = 4'd0;
        fifo_ext_empty = 1'b1;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, err, fifo_ext_rd} !== 4'b1000) begin
                errors++;
                $display("FAIL timeout_wait%0d {busy,done,err,fr} got %b want 1000", k,
                         {busy, done, err, fifo_ext_rd});
            end
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({busy, done, err, fifo_ext_rd} !== 4'b0010) begin
                errors++;
                $display("FAIL timeout_idle {busy,done,err,fr} got %b want 0010",
                         {busy, done, err, fifo_ext_rd});
            end
        end
        run_pass("after_timeout", 1, 0, 3, 0, 0, -1, dc);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_full();
        test_back_to_back();
        test_random();
`ifdef NORM_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
